// File: rtl/reg_file_mp.sv
// reg_file_mp: multi-port register file with combinational read ports, one
// byte-enabled synchronous write port, optional write-to-read bypass, optional
// hardwired-zero entry 0, and a sequenced clear engine that zeroes every entry
// after reset or on request.
module reg_file_mp #(
   parameter int DATA_WIDTH = 32,
   parameter int ADDR_WIDTH = 5,
   parameter int NUM_RD     = 2,
   parameter int BYPASS     = 1,
   parameter int ZERO_REG   = 1
) (
   input  logic                           clk,
   input  logic                           reset,
   input  logic                           clr_req,
   input  logic                           wr_en,
   input  logic [ADDR_WIDTH-1:0]          wr_addr,
   input  logic [DATA_WIDTH-1:0]          wr_data,
   input  logic [DATA_WIDTH/8-1:0]        wr_be,
   input  logic [NUM_RD*ADDR_WIDTH-1:0]   rd_addr,
   output logic [NUM_RD*DATA_WIDTH-1:0]   rd_data,
   output logic                           busy
);

   localparam int DEPTH     = 2 ** ADDR_WIDTH;
   localparam int NUM_BYTES = DATA_WIDTH / 8;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = '1;

   typedef enum logic {
      ST_CLEAR,
      ST_READY
   } state_t;

   state_t                  state;
   logic [ADDR_WIDTH-1:0]   clr_ptr;
   logic [DATA_WIDTH-1:0]   mem [DEPTH];

   logic                    wr_to_zero;
   logic                    wr_accept;
   logic                    clr_write;
   logic [DATA_WIDTH-1:0]   wr_merged;

   // Write qualification: clear and reset always win over a normal write.
   assign wr_to_zero = (ZERO_REG != 0) && (wr_addr == '0);
   assign wr_accept  = !reset && (state == ST_READY) && wr_en && !clr_req && !wr_to_zero;
   assign clr_write  = !reset && (state == ST_CLEAR);

   // Merge enabled write bytes over the currently stored entry; shared by the
   // storage update and the bypass path so both see the identical value.
   // NOTE: every variable assigned in always_comb gets a default first, so no latch is inferred.
   always_comb begin
      wr_merged = mem[wr_addr];
      for (int k = 0; k < NUM_BYTES; k++) begin
         if (wr_be[k]) wr_merged[8*k +: 8] = wr_data[8*k +: 8];
      end
   end

   // Control FSM: clear engine sequencing and the registered busy flag.
   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
         busy    <= 1'b1;
      end else if (state == ST_CLEAR) begin
         if (clr_ptr == LAST_ADDR) begin
            state <= ST_READY;
            busy  <= 1'b0;
         end else begin
            clr_ptr <= clr_ptr + 1'b1;
         end
      end else if (clr_req) begin
         state   <= ST_CLEAR;
         clr_ptr <= '0;
         busy    <= 1'b1;
      end
   end

   // Storage update: clear engine writes zero, otherwise the accepted write lands.
   // NOTE: the array has no reset branch; the clear engine zeroes it so it maps onto plain RAM/flops.
   always_ff @(posedge clk) begin
      if (clr_write) begin
         mem[clr_ptr] <= '0;
      end else if (wr_accept) begin
         mem[wr_addr] <= wr_merged;
      end
   end

   // Independent read ports: zero while clearing, bypass on a matching accepted
   // write, and entry 0 forced to zero when it is hardwired.
   for (genvar p = 0; p < NUM_RD; p++) begin : g_rd
      logic [ADDR_WIDTH-1:0] addr;
      logic [DATA_WIDTH-1:0] val;

      assign addr = rd_addr[p*ADDR_WIDTH +: ADDR_WIDTH];

      // Select the value presented on this port.
      always_comb begin
         val = '0;
         if (state == ST_READY) begin
            if ((BYPASS != 0) && wr_accept && (addr == wr_addr)) val = wr_merged;
            else                                                 val = mem[addr];
            if ((ZERO_REG != 0) && (addr == '0))                 val = '0;
         end
      end

      assign rd_data[p*DATA_WIDTH +: DATA_WIDTH] = val;
   end

endmodule

// File: doc/reg_file_mp.md
# reg_file_mp

Parametrised multi-port register file for the single-cycle RISC-V CPU and its successors. It provides a configurable depth, a configurable number of combinational read ports, and one synchronous write port with byte enables. An optional write-to-read bypass is included. A sequenced clear engine zeroes every entry after reset or on request, holding `busy` until done. Register 0 is optionally hardwired to zero.

## Interface
- `DATA_WIDTH`, 32: entry width in bits; must be a multiple of 8.
- `ADDR_WIDTH`, 5: address width; depth = 2**ADDR_WIDTH.
- `NUM_RD`, 2: number of read ports, ≥1.
- `BYPASS`, 1: 1 = a same-cycle write is forwarded to matching read ports; 0 = reads return the stored value.
- `ZERO_REG`, 1: 1 = entry 0 reads 0 and ignores writes.

- `clk`  in  1  single clock, all state updates on rising edge.
- `reset`  in  1  synchronous, active-high; starts a full clear.
- `clr_req`  in  1  pulse; starts a full clear when in READY.
- `wr_en`  in  1  write strobe.
- `wr_addr`  in  ADDR_WIDTH  write address.
- `wr_data`  in  DATA_WIDTH  write data.
- `wr_be`  in  DATA_WIDTH/8  byte enables; bit k covers bits [8k+7:8k].
- `rd_addr`  in  NUM_RD*ADDR_WIDTH  packed read addresses; port p uses slice [p*ADDR_WIDTH +: ADDR_WIDTH].
- `rd_data`  out  NUM_RD*DATA_WIDTH  packed read data, same packing; combinational.
- `busy`  out  1  high while the clear engine runs.

## Operation
- Two states:
  - CLEAR: clear engine active.
  - READY: normal operation.
- Clear counter `clr_ptr` is ADDR_WIDTH bits.
- Reset:
  - state ← CLEAR, `clr_ptr` ← 0, `busy` = 1.
  - Entry contents are not reset directly; they are cleared by the engine.
- CLEAR:
  - Each cycle writes 0 to entry `clr_ptr`, then increments `clr_ptr`.
  - When `clr_ptr` == DEPTH-1 is written, go to READY.
  - `wr_en` and `clr_req` are ignored.
  - All `rd_data` ports read 0.
- READY:
  - `busy` = 0.
  - `clr_req` = 1 → state CLEAR, `clr_ptr` ← 0. Any `wr_en` in that cycle is dropped, so clear wins.
  - `wr_en` = 1 with `clr_req` = 0: each byte k with `wr_be[k]` = 1 is updated from `wr_data`. Other bytes are retained.
  - `wr_be` = 0 with `wr_en` = 1 is a no-op.
- ZERO_REG = 1:
  - Writes to address 0 are dropped.
  - Reads of address 0 return 0 regardless of bypass.
- Read ports are independent. Any number may address the same entry.
- Bypass (BYPASS = 1, READY, `wr_en` = 1, `clr_req` = 0, `rd_addr[p]` == `wr_addr`, not a dropped address-0 write):
  - `rd_data[p]` = stored value with enabled bytes replaced by `wr_data` bytes. This equals the value the entry holds after the edge.
- BYPASS = 0: `rd_data[p]` = the stored value before the edge.

## Timing
- Read latency: combinational, 0 cycles.
- Write latency: the entry is updated on the rising edge where the write is accepted. It is visible through storage on the next cycle, or in the same cycle through bypass.
- Clear latency: `busy` is high for exactly DEPTH cycles after reset deasserts or after the `clr_req` edge (32 cycles at defaults). The first cycle with `busy` = 0 accepts writes.
- Reset asserted mid-clear: `clr_ptr` restarts at 0, and a full DEPTH-cycle clear follows the deassertion.
- Reset held for N cycles: `busy` stays 1 throughout, and `clr_ptr` stays 0.
- `clr_req` while `busy` = 1 is ignored. It does not restart or extend the clear.
- `clr_ptr` never wraps in normal operation. It stops at DEPTH-1 on the transition to READY.
- Simultaneous write and read of the same address: governed by BYPASS as above. A write never corrupts other ports' reads.

## Test plan
- Reset release:
  - Stimulus: release reset with defaults and write x5 = 0x1234_5678 during cycles 0–31.
  - Response: `busy` = 1 for 32 cycles, writes dropped, all reads 0. At cycle 32 `busy` = 0 and x5 still reads 0.
- Byte-enable write:
  - Stimulus: in READY write x7 = 0xAABB_CCDD with be = 4'b1111, then 0x1122_3344 with be = 4'b0101.
  - Response: x7 reads 0xAA22_CC44.
- Bypass:
  - Stimulus: BYPASS = 1, x3 holds 0x0000_00FF. Write x3 = 0xDEAD_BEEF with be = 4'b1100, with both ports reading x3 in the same cycle.
  - Response: both ports show 0xDEAD_00FF. With BYPASS = 0, both ports show 0x0000_00FF that cycle.
- Zero register:
  - Stimulus: write x0 = 0xFFFF_FFFF with be = 4'b1111 while port 0 reads x0.
  - Response: port 0 reads 0 that cycle and the next.
- Clear request:
  - Stimulus: fill x1..x31 with nonzero data, then pulse `clr_req` with `wr_en` = 1 to x9 in the same cycle.
  - Response: `busy` = 1 for 32 cycles, the x9 write is dropped, and all entries read 0 afterwards.
- Reset mid-clear:
  - Stimulus: during a clear at `clr_ptr` = 10, assert reset for 2 cycles; also pulse `clr_req` while busy.
  - Response: `busy` deasserts exactly 32 cycles after reset deasserts, and the `clr_req` has no effect.
